// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - Parametrised VGA timing generator with two-stage pixel pipeline
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8,
  parameter int ADDR_W   = 19
) (
  input  logic                   clk_50,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   pix_data,
  output logic                   pix_req,
  output logic [ADDR_W-1:0]      pix_addr,
  output logic                   hs,
  output logic                   vs,
  output logic                   de,
  output logic [COLOR_W-1:0]     r,
  output logic [COLOR_W-1:0]     g,
  output logic [COLOR_W-1:0]     b,
  output logic [10:0]            x,
  output logic [9:0]             y,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int H_END   = H_START + H_ACTIVE;
  localparam int V_START = V_SYNC + V_BP;
  localparam int V_END   = V_START + V_ACTIVE;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  // Divider and raster position
  logic [DW-1:0] div_q, div_d;
  logic          tick;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]    mode_q;
  logic          h_wrap, v_wrap, h_act, v_act, active, first_px, origin;

  // Stage 1: decoded position, RAM request
  logic          s1_hs_q, s1_vs_q, s1_de_q, s1_origin_q;
  logic [10:0]   s1_x_q;
  logic [9:0]    s1_y_q;
  logic [1:0]    s1_mode_q;
  logic          pix_req_q;
  logic [ADDR_W-1:0] pix_addr_q;

  // Stage 2: pin-facing registers
  logic          hs_q, vs_q, de_q, frame_start_q;
  logic [10:0]   x_q;
  logic [9:0]    y_q;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  int            bar_num;
  logic [2:0]    bar_idx;

  // Tick is high on the last divider count; CLK_DIV=1 gives a tick every cycle
  always_comb begin
    tick  = (int'(div_q) == CLK_DIV - 1);
    div_d = tick ? '0 : div_q + DW'(1);
  end

  // Raster decode; comparisons in int width so H_END == H_TOTAL cannot alias to zero
  always_comb begin
    h_wrap   = (int'(h_cnt_q) == H_TOTAL - 1);
    v_wrap   = (int'(v_cnt_q) == V_TOTAL - 1);
    h_act    = (int'(h_cnt_q) >= H_START) && (int'(h_cnt_q) < H_END);
    v_act    = (int'(v_cnt_q) >= V_START) && (int'(v_cnt_q) < V_END);
    active   = h_act && v_act;
    first_px = (int'(h_cnt_q) == H_START) && (int'(v_cnt_q) == V_START);
    origin   = (h_cnt_q == '0) && (v_cnt_q == '0);
    h_cnt_d  = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_cnt_d  = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
    end
  end

  // Divider, counters, and once-per-frame mode capture so a frame never mixes sources
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      mode_q  <= 2'd0;
    end else begin
      div_q <= div_d;
      if (tick) begin
        h_cnt_q <= h_cnt_d;
        v_cnt_q <= v_cnt_d;
        if (origin) begin
          mode_q <= mode;
        end
      end
    end
  end

  // Stage 1: sync levels, coordinates and a one-cycle RAM read strobe with linear address
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      s1_hs_q     <= ~HS_POL;
      s1_vs_q     <= ~VS_POL;
      s1_de_q     <= 1'b0;
      s1_origin_q <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_mode_q   <= 2'd0;
      pix_req_q   <= 1'b0;
      pix_addr_q  <= '0;
    end else begin
      pix_req_q <= tick && active && (mode_q == 2'd0);
      if (tick) begin
        s1_hs_q     <= (int'(h_cnt_q) < H_SYNC) ? HS_POL : ~HS_POL;
        s1_vs_q     <= (int'(v_cnt_q) < V_SYNC) ? VS_POL : ~VS_POL;
        s1_de_q     <= active;
        s1_origin_q <= origin;
        s1_x_q      <= active ? 11'(int'(h_cnt_q) - H_START) : 11'd0;
        s1_y_q      <= active ? 10'(int'(v_cnt_q) - V_START) : 10'd0;
        s1_mode_q   <= mode_q;
        if (active) begin
          pix_addr_q <= first_px ? '0 : pix_addr_q + ADDR_W'(1);
        end
      end
    end
  end

  // Colour source select; RAM data has arrived by the stage-2 tick
  always_comb begin
    bar_num = int'(s1_x_q) / BAR_W;
    bar_idx = (bar_num > 7) ? 3'd7 : 3'(bar_num);
    rgb_d   = '0;
    if (s1_de_q) begin
      case (s1_mode_q)
        2'd0:    rgb_d = pix_data;
        2'd1:    rgb_d = {{COLOR_W{~bar_idx[1]}}, {COLOR_W{~bar_idx[2]}}, {COLOR_W{~bar_idx[0]}}};
        2'd2:    rgb_d = {3{COLOR_W'(s1_x_q)}};
        default: rgb_d = '0;
      endcase
    end
  end

  // Stage 2: align sync, de, coordinates and colour at the pins
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= tick && s1_origin_q;
      if (tick) begin
        hs_q  <= s1_hs_q;
        vs_q  <= s1_vs_q;
        de_q  <= s1_de_q;
        x_q   <= s1_x_q;
        y_q   <= s1_y_q;
        rgb_q <= rgb_d;
      end
    end
  end

  assign pix_req     = pix_req_q;
  assign pix_addr    = pix_addr_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign r           = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign g           = rgb_q[2*COLOR_W-1:COLOR_W];
  assign b           = rgb_q[COLOR_W-1:0];
  assign frame_start = frame_start_q;

endmodule
